// File: rtl/rtc_prog_sequencer_pkg.sv
// Shared types and constants for the RTC programming sequencer.
// Holds the FSM state encoding, the data-mux select codes and the default RTC addresses.
package rtc_prog_pkg;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_INIT_A = 4'd1,
        S_INIT_D = 4'd2,
        S_REG_A  = 4'd3,
        S_REG_D  = 4'd4,
        S_CTL_A  = 4'd5,
        S_CTL_D  = 4'd6,
        S_FIN    = 4'd7,
        S_RDST   = 4'd8,
        S_ERR    = 4'd9
    } state_t;

    localparam logic [1:0] DS_INIT_ADDR = 2'b00;
    localparam logic [1:0] DS_INIT_CMD  = 2'b01;
    localparam logic [1:0] DS_IDLE      = 2'b10;
    localparam logic [1:0] DS_USER      = 2'b11;

    localparam logic [3:0] DEF_BASE_ADDR = 4'h4;
    localparam logic [3:0] DEF_CTRL_ADDR = 4'hD;

endpackage

// File: rtl/rtc_prog_sequencer_if.sv
// Control/handshake bundle between the sequencer (master) and the bus timing
// generator / datapath side (slave).
interface rtc_prog_sequencer_if #(
    parameter int ADDR_W = 4,
    parameter int SEL_W  = 4
);
    logic              start;
    logic              abort;
    logic              bus_done;
    logic              op_w;
    logic              i_w;
    logic              ad_w;
    logic [ADDR_W-1:0] addr_w;
    logic [SEL_W-1:0]  sel_prog;
    logic [1:0]        data_sel;
    logic              fin_w;
    logic              inicio_e;
    logic              busy;
    logic              err;

    modport master (
        input  start, abort, bus_done,
        output op_w, i_w, ad_w, addr_w, sel_prog, data_sel, fin_w, inicio_e, busy, err
    );

    modport slave (
        output start, abort, bus_done,
        input  op_w, i_w, ad_w, addr_w, sel_prog, data_sel, fin_w, inicio_e, busy, err
    );
endinterface

// File: rtl/rtc_prog_sequencer_phase_timer.sv
// Per-phase wait counter: counts cycles spent waiting for bus_done and flags the
// last permitted cycle so the FSM can give up on that edge.
module rtc_phase_timer #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_timeout
);
    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] r_cnt;
    logic          w_tc;

    // Terminal count marks the TIMEOUT_CYC-th cycle spent in the current phase.
    assign w_tc      = (r_cnt == CW'(TIMEOUT_CYC - 1));
    assign o_timeout = i_en && w_tc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && !w_tc) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end
endmodule

// File: rtl/rtc_prog_sequencer.sv
// Autonomous RTC write sequencer: init transaction, N_REGS user writes, optional
// control write, then completion and optional read-start pulse.
// IDLE wait | INIT_A/D init txn | REG_A/D user reg idx | CTL_A/D ctrl reg
// FIN done pulse | RDST read-start pulse | ERR phase timed out, err sticky
module rtc_prog_sequencer
    import rtc_prog_pkg::*;
#(
    parameter int              ADDR_W      = 4,
    parameter int              SEL_W       = 4,
    parameter int              N_REGS      = 10,
    parameter logic [ADDR_W-1:0] BASE_ADDR = DEF_BASE_ADDR,
    parameter bit              EN_CTRL     = 1'b1,
    parameter logic [ADDR_W-1:0] CTRL_ADDR = DEF_CTRL_ADDR,
    parameter bit              AUTO_READ   = 1'b1,
    parameter int              TIMEOUT_CYC = 255
) (
    input  logic                clk,
    input  logic                reset,
    rtc_prog_sequencer_if.master bus
);
    if (N_REGS < 1) begin : g_bad_nregs
        $fatal(1, "N_REGS must be at least 1");
    end
    if (N_REGS > (1 << SEL_W)) begin : g_bad_sel
        $fatal(1, "N_REGS exceeds the sel_prog range");
    end
    if (int'(BASE_ADDR) + N_REGS - 1 >= (1 << ADDR_W)) begin : g_bad_addr
        $fatal(1, "user register addresses overflow addr_w");
    end
    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $fatal(1, "TIMEOUT_CYC must be at least 1");
    end

    state_t             r_state, w_state_nxt;
    logic [SEL_W-1:0]   r_idx, w_idx_nxt;
    logic               w_phase, w_timeout, w_tmr_clr;

    logic               r_op_w, r_i_w, r_ad_w, r_fin_w, r_inicio_e, r_busy, r_err;
    logic [ADDR_W-1:0]  r_addr_w;
    logic [SEL_W-1:0]   r_sel_prog;
    logic [1:0]         r_data_sel;

    assign w_phase   = r_state inside {S_INIT_A, S_INIT_D, S_REG_A, S_REG_D, S_CTL_A, S_CTL_D};
    assign w_tmr_clr = !w_phase || (w_state_nxt != r_state);

    rtc_phase_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
        .clk       (clk),
        .rst       (reset),
        .i_clr     (w_tmr_clr),
        .i_en      (w_phase),
        .o_timeout (w_timeout)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        if (bus.abort && r_state != S_IDLE) begin
            w_state_nxt = S_IDLE;
            w_idx_nxt   = '0;
        end else if (w_phase && !bus.bus_done) begin
            // bus_done on the terminal cycle is a success, hence the timeout sits below it.
            if (w_timeout) begin
                w_state_nxt = S_ERR;
                w_idx_nxt   = '0;
            end
        end else begin
            case (r_state)
                S_IDLE:   if (bus.start) w_state_nxt = S_INIT_A;
                S_ERR:    if (bus.start) w_state_nxt = S_INIT_A;
                S_INIT_A: w_state_nxt = S_INIT_D;
                S_INIT_D: begin
                    w_state_nxt = S_REG_A;
                    w_idx_nxt   = '0;
                end
                S_REG_A:  w_state_nxt = S_REG_D;
                S_REG_D: begin
                    if (r_idx == SEL_W'(N_REGS - 1)) begin
                        w_state_nxt = EN_CTRL ? S_CTL_A : S_FIN;
                        w_idx_nxt   = '0;
                    end else begin
                        w_state_nxt = S_REG_A;
                        w_idx_nxt   = r_idx + SEL_W'(1);
                    end
                end
                S_CTL_A:  w_state_nxt = S_CTL_D;
                S_CTL_D:  w_state_nxt = S_FIN;
                S_FIN:    w_state_nxt = AUTO_READ ? S_RDST : S_IDLE;
                S_RDST:   w_state_nxt = S_IDLE;
                default:  w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_idx      <= '0;
            r_op_w     <= 1'b0;
            r_i_w      <= 1'b0;
            r_ad_w     <= 1'b0;
            r_addr_w   <= '0;
            r_sel_prog <= '0;
            r_data_sel <= DS_IDLE;
            r_fin_w    <= 1'b0;
            r_inicio_e <= 1'b0;
            r_busy     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_idx      <= w_idx_nxt;
            r_op_w     <= 1'b0;
            r_i_w      <= 1'b0;
            r_ad_w     <= 1'b0;
            r_addr_w   <= '0;
            r_sel_prog <= '0;
            r_data_sel <= DS_IDLE;
            r_fin_w    <= 1'b0;
            r_inicio_e <= 1'b0;
            r_busy     <= !(w_state_nxt inside {S_IDLE, S_ERR});
            if (w_state_nxt == S_ERR)
                r_err <= 1'b1;
            else if (r_state == S_ERR && w_state_nxt == S_INIT_A)
                r_err <= 1'b0;
            // Outputs are decoded from the next state so they move on the same edge.
            case (w_state_nxt)
                S_INIT_A, S_INIT_D: begin
                    r_op_w     <= 1'b1;
                    r_i_w      <= 1'b1;
                    r_ad_w     <= (w_state_nxt == S_INIT_D);
                    r_data_sel <= (w_state_nxt == S_INIT_D) ? DS_INIT_CMD : DS_INIT_ADDR;
                end
                S_REG_A, S_REG_D: begin
                    r_op_w     <= 1'b1;
                    r_i_w      <= 1'b1;
                    r_ad_w     <= (w_state_nxt == S_REG_D);
                    r_addr_w   <= BASE_ADDR + ADDR_W'(w_idx_nxt);
                    r_sel_prog <= w_idx_nxt;
                    r_data_sel <= DS_USER;
                end
                S_CTL_A, S_CTL_D: begin
                    r_op_w     <= 1'b1;
                    r_i_w      <= 1'b1;
                    r_ad_w     <= (w_state_nxt == S_CTL_D);
                    r_addr_w   <= CTRL_ADDR;
                    r_data_sel <= DS_USER;
                end
                S_FIN:   r_fin_w    <= 1'b1;
                S_RDST:  r_inicio_e <= 1'b1;
                default: ;
            endcase
        end
    end

    assign bus.op_w     = r_op_w;
    assign bus.i_w      = r_i_w;
    assign bus.ad_w     = r_ad_w;
    assign bus.addr_w   = r_addr_w;
    assign bus.sel_prog = r_sel_prog;
    assign bus.data_sel = r_data_sel;
    assign bus.fin_w    = r_fin_w;
    assign bus.inicio_e = r_inicio_e;
    assign bus.busy     = r_busy;
    assign bus.err      = r_err;
endmodule

// File: tb/tb_rtc_prog_sequencer.sv
// Directed bench: default sequencer plus a short variant (1 reg, no ctrl, no read, timeout 5).
module tb_rtc_prog_sequencer;
    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    rtc_prog_sequencer_if #(.ADDR_W(4), .SEL_W(4)) b0 ();
    rtc_prog_sequencer_if #(.ADDR_W(4), .SEL_W(4)) b1 ();

    rtc_prog_sequencer u0 (
        .clk   (clk),
        .reset (rst),
        .bus   (b0)
    );

    rtc_prog_sequencer #(
        .N_REGS      (1),
        .EN_CTRL     (1'b0),
        .AUTO_READ   (1'b0),
        .TIMEOUT_CYC (5)
    ) u1 (
        .clk   (clk),
        .reset (rst),
        .bus   (b1)
    );

    logic [16:0] o0, o1;
    assign o0 = {b0.op_w, b0.i_w, b0.ad_w, b0.addr_w, b0.sel_prog, b0.data_sel,
                 b0.fin_w, b0.inicio_e, b0.busy, b0.err};
    assign o1 = {b1.op_w, b1.i_w, b1.ad_w, b1.addr_w, b1.sel_prog, b1.data_sel,
                 b1.fin_w, b1.inicio_e, b1.busy, b1.err};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [16:0] vec(input bit op, input bit iw, input bit ad, input int addr,
                                        input int sel, input int ds, input bit fin, input bit ini,
                                        input bit bsy, input bit er);
        return {op, iw, ad, 4'(addr), 4'(sel), 2'(ds), fin, ini, bsy, er};
    endfunction

    function automatic logic [16:0] v_ph(input bit ad, input int addr, input int sel, input int ds);
        return vec(1, 1, ad, addr, sel, ds, 0, 0, 1, 0);
    endfunction

    function automatic logic [16:0] v_idle(input bit er);
        return vec(0, 0, 0, 0, 0, 2, 0, 0, 0, er);
    endfunction

    task automatic chk(input string tag, input logic [16:0] obs, input logic [16:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1;
        b0.start = 0; b0.abort = 0; b0.bus_done = 0;
        b1.start = 0; b1.abort = 0; b1.bus_done = 0;
        #3;
        chk("reset_u0", o0, v_idle(0));
        chk("reset_u1", o1, v_idle(0));
        step;
        rst = 1'b0;
        step;
        chk("idle_after_reset", o0, v_idle(0));

        // Full run on defaults, bus_done held high.
        b0.start = 1; b0.bus_done = 1;
        step; b0.start = 0;
        chk("A_init_a", o0, v_ph(0, 0, 0, 0));
        step; chk("A_init_d", o0, v_ph(1, 0, 0, 1));
        for (int k = 0; k < 10; k++) begin
            step; chk($sformatf("A_reg_a%0d", k), o0, v_ph(0, 4 + k, k, 3));
            step; chk($sformatf("A_reg_d%0d", k), o0, v_ph(1, 4 + k, k, 3));
        end
        step; chk("A_ctl_a", o0, v_ph(0, 13, 0, 3));
        step; chk("A_ctl_d", o0, v_ph(1, 13, 0, 3));
        step; chk("A_fin", o0, vec(0, 0, 0, 0, 0, 2, 1, 0, 1, 0));
        step; chk("A_rdst", o0, vec(0, 0, 0, 0, 0, 2, 0, 1, 1, 0));
        step; chk("A_idle", o0, v_idle(0));
        step; chk("A_idle_hold", o0, v_idle(0));
        b0.bus_done = 0;

        // Handshake stall in REG_A idx=2.
        b0.start = 1; b0.bus_done = 1;
        step; b0.start = 0;
        repeat (5) step;
        step; b0.bus_done = 0;
        chk("B_reg_a2", o0, v_ph(0, 6, 2, 3));
        for (int i = 0; i < 7; i++) begin
            step; chk($sformatf("B_stall%0d", i), o0, v_ph(0, 6, 2, 3));
        end
        b0.bus_done = 1;
        step; b0.bus_done = 0;
        chk("B_reg_d2", o0, v_ph(1, 6, 2, 3));
        step; chk("B_reg_d2_hold", o0, v_ph(1, 6, 2, 3));
        b0.abort = 1;
        step; b0.abort = 0;
        chk("B_abort_idle", o0, v_idle(0));

        // Abort and bus_done together in REG_D idx=9.
        b0.start = 1; b0.bus_done = 1;
        step; b0.start = 0;
        repeat (21) step;
        chk("C_reg_d9", o0, v_ph(1, 13, 9, 3));
        b0.abort = 1;
        step; b0.abort = 0; b0.bus_done = 0;
        chk("C_abort", o0, v_idle(0));
        step; chk("C_no_fin", o0, v_idle(0));

        // Async reset in REG_D idx=3, then restart.
        b0.start = 1; b0.bus_done = 1;
        step; b0.start = 0;
        repeat (9) step;
        b0.bus_done = 0;
        chk("D_reg_d3", o0, v_ph(1, 7, 3, 3));
        #2 rst = 1'b1;
        #1 chk("D_reset_async", o0, v_idle(0));
        #2 rst = 1'b0;
        step; chk("D_idle_after", o0, v_idle(0));
        b0.start = 1; b0.bus_done = 1;
        step; b0.start = 0;
        chk("D_restart_init_a", o0, v_ph(0, 0, 0, 0));
        step; step;
        chk("D_restart_reg_a0", o0, v_ph(0, 4, 0, 3));
        b0.abort = 1;
        step; b0.abort = 0; b0.bus_done = 0;
        chk("D_abort", o0, v_idle(0));

        // Variant: one register, no ctrl, no read-start; start while busy.
        b1.start = 1; b1.bus_done = 1;
        step; b1.start = 0;
        chk("E_init_a", o1, v_ph(0, 0, 0, 0));
        step; b1.start = 1;
        chk("E_init_d", o1, v_ph(1, 0, 0, 1));
        step; b1.start = 0;
        chk("E_reg_a0", o1, v_ph(0, 4, 0, 3));
        step; chk("E_reg_d0", o1, v_ph(1, 4, 0, 3));
        step; chk("E_fin", o1, vec(0, 0, 0, 0, 0, 2, 1, 0, 1, 0));
        step; chk("E_idle_no_rdst", o1, v_idle(0));
        step; chk("E_idle_hold", o1, v_idle(0));
        b1.bus_done = 0;

        // Timeout in INIT_D (TIMEOUT_CYC=5).
        b1.start = 1; b1.bus_done = 1;
        step; b1.start = 0;
        step; b1.bus_done = 0;
        chk("F_init_d", o1, v_ph(1, 0, 0, 1));
        for (int i = 0; i < 4; i++) begin
            step; chk($sformatf("F_wait%0d", i), o1, v_ph(1, 0, 0, 1));
        end
        step; chk("F_err", o1, v_idle(1));
        b1.bus_done = 1;
        step; b1.bus_done = 0;
        chk("F_err_hold", o1, v_idle(1));
        b1.start = 1; b1.bus_done = 1;
        step; b1.start = 0; b1.bus_done = 0;
        chk("F_restart_clears_err", o1, v_ph(0, 0, 0, 0));
        repeat (4) step;
        chk("F_terminal_cycle", o1, v_ph(0, 0, 0, 0));
        b1.bus_done = 1;
        step; b1.bus_done = 0;
        chk("F_done_at_limit", o1, v_ph(1, 0, 0, 1));
        b1.abort = 1;
        step; b1.abort = 0;
        chk("F_abort", o1, v_idle(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
